gen_pcm_wave: RTL and testbench

//  Parametrised multi-mode PCM test-signal source; next generation of the sawtooth PCM generator.

---
 rtl/pcm_gen_pkg.sv | 31 +++
 rtl/pcm_lfsr16.sv | 33 +++
 rtl/gen_pcm_wave.sv | 185 ++++++++++++++++++
 tb/tb_gen_pcm_wave.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/pcm_gen_pkg.sv
// Shared definitions for the PCM test-signal generator: mode encodings, LFSR taps and helpers.
package pcm_gen_pkg;

  localparam int unsigned MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    MODE_SAW    = 3'd0,
    MODE_TRI    = 3'd1,
    MODE_SQUARE = 3'd2,
    MODE_PRBS   = 3'd3,
    MODE_CONST  = 3'd4
  } mode_e;

  typedef enum logic {
    DirUp   = 1'b0,
    DirDown = 1'b1
  } dir_e;

  // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1: feedback from bits 0,2,3,5.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic logic [15:0] lfsr_step(logic [15:0] s);
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction

  // Encodings above CONST are folded onto CONST so mode comparisons stay meaningful.
  function automatic mode_e decode_mode(logic [MODE_W-1:0] m);
    return (m > MODE_CONST) ? MODE_CONST : mode_e'(m);
  endfunction

endpackage

// File: rtl/pcm_lfsr16.sv
// 16-bit PRBS register; exposes the look-ahead value it will hold once this cycle's shift lands.
module pcm_lfsr16
  import pcm_gen_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        restart,
  input  logic        shift_en,
  output logic [15:0] state,
  output logic        at_seed
);

  logic [15:0] lfsr_q, lfsr_d, base;

  always_comb begin
    // A restart re-seeds before the shift, so a restarted sample is one step past SEED.
    base    = restart ? SEED : lfsr_q;
    state   = lfsr_step(base);
    at_seed = (state == SEED);
    lfsr_d  = shift_en ? state : base;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

endmodule

// File: rtl/gen_pcm_wave.sv
// Multi-mode PCM test-signal source (saw, triangle, square, PRBS, constant).
// One registered sample per sample_en strobe; config loads take effect on the next later strobe.
module gen_pcm_wave
  import pcm_gen_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned STEP_W    = 8,
  parameter logic [15:0] PRBS_SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_en,
  input  logic              cfg_load,
  input  logic [MODE_W-1:0] mode_in,
  input  logic [STEP_W-1:0] step_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              wrap
);

  localparam int unsigned SumW = DATA_W + 1;
  localparam int unsigned ExtW = (STEP_W > SumW) ? STEP_W : SumW;
  localparam logic [DATA_W-1:0] MaxData = {DATA_W{1'b1}};
  localparam logic [SumW-1:0] MaxVal = {1'b0, MaxData};

  mode_e             mode_q, mode_d, pend_mode_q, pend_mode_d, eff_mode;
  logic [STEP_W-1:0] step_q, step_d, pend_step_q, pend_step_d, eff_step, half_m1;
  logic              pend_valid_q, pend_valid_d;
  logic [DATA_W-1:0] acc_q, acc_d, acc_base;
  dir_e              dir_q, dir_d, dir_base;
  logic [STEP_W-1:0] sq_cnt_q, sq_cnt_d, sq_cnt_base;
  logic              sq_lvl_q, sq_lvl_d, sq_lvl_base;
  logic [DATA_W-1:0] data_out_q, data_out_d, sample;
  logic              data_valid_q, data_valid_d, wrap_q, wrap_d, wrap_c;
  logic              apply, restart, prbs_shift, lfsr_at_seed;
  logic [15:0]       lfsr_nxt;
  logic [ExtW-1:0]   step_wide;
  logic [SumW-1:0]   step_ext, acc_ext, sum, diff;

  pcm_lfsr16 #(
    .SEED(PRBS_SEED)
  ) u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (restart),
    .shift_en(prbs_shift),
    .state   (lfsr_nxt),
    .at_seed (lfsr_at_seed)
  );

  always_comb begin
    apply       = sample_en & pend_valid_q;
    restart     = apply && (pend_mode_q != mode_q);
    eff_mode    = apply ? pend_mode_q : mode_q;
    eff_step    = apply ? pend_step_q : step_q;
    acc_base    = restart ? '0 : acc_q;
    dir_base    = restart ? DirUp : dir_q;
    sq_cnt_base = restart ? '0 : sq_cnt_q;
    sq_lvl_base = restart ? 1'b0 : sq_lvl_q;
    prbs_shift  = sample_en && (eff_mode == MODE_PRBS);
    step_wide   = ExtW'(eff_step);
    step_ext    = step_wide[SumW-1:0];
    acc_ext     = {1'b0, acc_base};
    sum         = acc_ext + step_ext;
    diff        = acc_ext - step_ext;
    // A zero half-period behaves as one sample per level.
    half_m1     = (eff_step == '0) ? '0 : eff_step - STEP_W'(1);
  end

  always_comb begin
    mode_d       = mode_q;
    step_d       = step_q;
    acc_d        = acc_q;
    dir_d        = dir_q;
    sq_cnt_d     = sq_cnt_q;
    sq_lvl_d     = sq_lvl_q;
    pend_valid_d = pend_valid_q;
    pend_mode_d  = pend_mode_q;
    pend_step_d  = pend_step_q;
    sample       = data_out_q;
    wrap_c       = 1'b0;

    // A load in the same cycle as an apply becomes the new pending entry.
    if (cfg_load) begin
      pend_valid_d = 1'b1;
      pend_mode_d  = decode_mode(mode_in);
      pend_step_d  = step_in;
    end else if (apply) begin
      pend_valid_d = 1'b0;
    end

    if (sample_en) begin
      mode_d   = eff_mode;
      step_d   = eff_step;
      acc_d    = acc_base;
      dir_d    = dir_base;
      sq_cnt_d = sq_cnt_base;
      sq_lvl_d = sq_lvl_base;
      case (eff_mode)
        MODE_SAW: begin
          acc_d  = sum[DATA_W-1:0];
          wrap_c = sum[DATA_W];
          sample = sum[DATA_W-1:0];
        end
        MODE_TRI: begin
          if (step_ext == '0) begin
            acc_d = acc_base;
          end else if (dir_base == DirUp) begin
            if (sum >= MaxVal) begin
              acc_d = MaxData;
              dir_d = DirDown;
            end else begin
              acc_d = sum[DATA_W-1:0];
            end
          end else begin
            if (acc_ext <= step_ext) begin
              acc_d  = '0;
              dir_d  = DirUp;
              wrap_c = 1'b1;
            end else begin
              acc_d = diff[DATA_W-1:0];
            end
          end
          sample = acc_d;
        end
        MODE_SQUARE: begin
          if (sq_cnt_base >= half_m1) begin
            sq_cnt_d = '0;
            sq_lvl_d = ~sq_lvl_base;
            wrap_c   = sq_lvl_base;
          end else begin
            sq_cnt_d = sq_cnt_base + STEP_W'(1);
          end
          sample = sq_lvl_d ? MaxData : '0;
        end
        MODE_PRBS: begin
          sample = DATA_W'(lfsr_nxt);
          wrap_c = lfsr_at_seed;
        end
        default: begin
          sample = step_wide[DATA_W-1:0];
        end
      endcase
    end

    data_out_d   = sample;
    data_valid_d = sample_en;
    wrap_d       = sample_en & wrap_c;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q       <= MODE_SAW;
      step_q       <= STEP_W'(1);
      pend_valid_q <= 1'b0;
      pend_mode_q  <= MODE_SAW;
      pend_step_q  <= '0;
      acc_q        <= '0;
      dir_q        <= DirUp;
      sq_cnt_q     <= '0;
      sq_lvl_q     <= 1'b0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      wrap_q       <= 1'b0;
    end else begin
      mode_q       <= mode_d;
      step_q       <= step_d;
      pend_valid_q <= pend_valid_d;
      pend_mode_q  <= pend_mode_d;
      pend_step_q  <= pend_step_d;
      acc_q        <= acc_d;
      dir_q        <= dir_d;
      sq_cnt_q     <= sq_cnt_d;
      sq_lvl_q     <= sq_lvl_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      wrap_q       <= wrap_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign wrap       = wrap_q;

endmodule

// File: tb/tb_gen_pcm_wave.sv
// Directed bench for gen_pcm_wave: expected samples are queued at each strobe and checked next cycle.
module tb_gen_pcm_wave;

  logic       clk = 1'b0;
  logic       rst_n, sample_en, cfg_load;
  logic [2:0] mode_in;
  logic [7:0] step_in;
  logic [7:0] data_out;
  logic       data_valid, wrap;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] d;
    logic       w;
    string      tag;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] lf;
  int          bad, wraps;

  always #5 clk = ~clk;

  gen_pcm_wave #(
    .DATA_W   (8),
    .STEP_W   (8),
    .PRBS_SEED(16'hACE1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sample_en (sample_en),
    .cfg_load  (cfg_load),
    .mode_in   (mode_in),
    .step_in   (step_in),
    .data_out  (data_out),
    .data_valid(data_valid),
    .wrap      (wrap)
  );

  function automatic logic [15:0] model_lfsr(logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) return;
    e = sb.pop_front();
    chk({e.tag, "_valid"}, 16'(data_valid), 16'd1);
    chk({e.tag, "_data"}, 16'(data_out), 16'(e.d));
    chk({e.tag, "_wrap"}, 16'(wrap), 16'(e.w));
  endtask

  task automatic strobe(input logic [7:0] d, input logic w, input string tag);
    sb.push_back('{d: d, w: w, tag: tag});
    sample_en = 1'b1;
    @(posedge clk);
    #1;
    sample_en = 1'b0;
    check_out();
  endtask

  task automatic idle(input logic [7:0] d, input string tag);
    @(posedge clk);
    #1;
    chk({tag, "_valid"}, 16'(data_valid), 16'd0);
    chk({tag, "_wrap"}, 16'(wrap), 16'd0);
    chk({tag, "_data"}, 16'(data_out), 16'(d));
  endtask

  task automatic cfg(input logic [2:0] m, input logic [7:0] s);
    cfg_load = 1'b1;
    mode_in  = m;
    step_in  = s;
    @(posedge clk);
    #1;
    cfg_load = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    sample_en = 1'b0;
    cfg_load  = 1'b0;
    mode_in   = 3'd0;
    step_in   = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_data", 16'(data_out), 16'd0);
    chk("reset_valid", 16'(data_valid), 16'd0);
    chk("reset_wrap", 16'(wrap), 16'd0);
    rst_n = 1'b1;

    // Default saw, step 1, back-to-back strobes across the wrap.
    for (int i = 1; i <= 300; i++) begin
      strobe(8'(i), (8'(i) == 8'd0), "saw1");
    end
    idle(8'd44, "saw1_hold");

    do_reset();
    cfg(3'd0, 8'd100);
    strobe(8'd100, 1'b0, "saw100_a");
    strobe(8'd200, 1'b0, "saw100_b");
    strobe(8'd44, 1'b1, "saw100_c");
    strobe(8'd144, 1'b0, "saw100_d");
    strobe(8'd244, 1'b0, "saw100_e");
    strobe(8'd88, 1'b1, "saw100_f");

    cfg(3'd1, 8'd100);
    strobe(8'd100, 1'b0, "tri_a");
    strobe(8'd200, 1'b0, "tri_b");
    strobe(8'd255, 1'b0, "tri_peak");
    strobe(8'd155, 1'b0, "tri_c");
    strobe(8'd55, 1'b0, "tri_d");
    strobe(8'd0, 1'b1, "tri_floor");
    strobe(8'd100, 1'b0, "tri_e");
    cfg(3'd1, 8'd0);
    strobe(8'd100, 1'b0, "tri0_a");
    strobe(8'd100, 1'b0, "tri0_b");
    idle(8'd100, "tri0_hold");

    cfg(3'd2, 8'd3);
    strobe(8'd0, 1'b0, "sq_1");
    strobe(8'd0, 1'b0, "sq_2");
    strobe(8'd255, 1'b0, "sq_3");
    strobe(8'd255, 1'b0, "sq_4");
    strobe(8'd255, 1'b0, "sq_5");
    strobe(8'd0, 1'b1, "sq_6");
    strobe(8'd0, 1'b0, "sq_7");
    strobe(8'd0, 1'b0, "sq_8");
    strobe(8'd255, 1'b0, "sq_9");
    cfg(3'd2, 8'd0);
    strobe(8'd0, 1'b1, "sq0_a");
    strobe(8'd255, 1'b0, "sq0_b");
    strobe(8'd0, 1'b1, "sq0_c");
    strobe(8'd255, 1'b0, "sq0_d");

    // PRBS restarts from the seed on entry; check the first strobes, then the full period.
    cfg(3'd3, 8'd0);
    lf = 16'hACE1;
    for (int n = 1; n <= 16; n++) begin
      lf = model_lfsr(lf);
      strobe(lf[7:0], (lf == 16'hACE1), "prbs");
    end
    bad       = 0;
    wraps     = 0;
    sample_en = 1'b1;
    for (int n = 17; n <= 65534; n++) begin
      @(posedge clk);
      #1;
      lf = model_lfsr(lf);
      if (data_out !== lf[7:0] || data_valid !== 1'b1) bad++;
      if (wrap !== 1'b0) wraps++;
    end
    lf = model_lfsr(lf);
    strobe(lf[7:0], 1'b1, "prbs_period");
    chk("prbs_stream", 16'(bad), 16'd0);
    chk("prbs_early_wrap", 16'(wraps), 16'd0);

    cfg(3'd4, 8'h5A);
    strobe(8'h5A, 1'b0, "const_a");
    strobe(8'h5A, 1'b0, "const_b");
    cfg(3'd7, 8'h33);
    strobe(8'h33, 1'b0, "const_m7");
    idle(8'h33, "const_hold");

    // Load coinciding with a strobe: that sample keeps the old config.
    do_reset();
    mode_in   = 3'd1;
    step_in   = 8'd50;
    cfg_load  = 1'b1;
    sample_en = 1'b1;
    sb.push_back('{d: 8'd1, w: 1'b0, tag: "ho_same_cycle"});
    @(posedge clk);
    #1;
    cfg_load  = 1'b0;
    sample_en = 1'b0;
    check_out();
    strobe(8'd50, 1'b0, "ho_tri_first");
    strobe(8'd100, 1'b0, "ho_tri_second");
    cfg(3'd2, 8'd3);
    cfg(3'd4, 8'h77);
    strobe(8'h77, 1'b0, "ho_last_wins");
    cfg(3'd1, 8'd50);
    strobe(8'd50, 1'b0, "ho_tri_again");
    strobe(8'd100, 1'b0, "ho_tri_again2");

    // Reset mid-run, with a strobe held high, aborts everything.
    rst_n     = 1'b0;
    sample_en = 1'b1;
    @(posedge clk);
    #1;
    sample_en = 1'b0;
    rst_n     = 1'b1;
    chk("midrst_data", 16'(data_out), 16'd0);
    chk("midrst_valid", 16'(data_valid), 16'd0);
    chk("midrst_wrap", 16'(wrap), 16'd0);
    strobe(8'd1, 1'b0, "post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
